// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks: register word
// addresses and a constant-evaluable ceiling log2 used to size counters.
package nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_EDGE_SEL     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_system_pio_debounce.sv
// One input channel: two-flop synchroniser followed by an optional
// stable-count debounce filter. With DEBOUNCE_CYCLES = 0 the filtered
// output is the second synchroniser flop directly.
module nios_system_pio_debounce
  import nios_system_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_filt
);

  logic r_sync1;
  logic r_sync2;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_filt = r_sync2;
    end else begin : g_filter
      localparam int CW_RAW = clog2(DEBOUNCE_CYCLES + 1);
      localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_filt;

      // Accept a new level only after it has differed from the filtered
      // value for DEBOUNCE_CYCLES consecutive cycles; any return resets the run.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt  <= '0;
          r_filt <= IDLE_LEVEL;
        end else if (r_sync2 == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_filt = r_filt;
    end
  endgenerate

endmodule

// File: rtl/nios_system_pio_edge_irq.sv
// Avalon-MM input PIO with per-channel synchroniser/debounce, per-bit
// programmable edge detection, sticky edge capture and a maskable
// level interrupt. Register map: 0 DATA (RO), 1 EDGE_SEL, 2 IRQ_MASK,
// 3 EDGE_CAPTURE (write-1-to-clear, a same-cycle edge wins over clear).
module nios_system_pio_edge_irq
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter bit BOTH_EDGES      = 1'b0,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic             w_unused_writedata;

  logic [WIDTH-1:0] r_edge_sel;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_capture;
  logic [WIDTH-1:0] r_prev;
  logic [31:0]      r_readdata;
  logic             r_irq;

  assign w_wr               = chipselect & ~write_n;
  assign w_wdata            = writedata[WIDTH-1:0];
  assign w_unused_writedata = ^writedata;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      nios_system_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_chan (
        .i_clk  (clk),
        .i_rst_n(reset_n),
        .i_pin  (in_port[g]),
        .o_filt (w_filt[g])
      );
    end
  endgenerate

  assign w_rise = w_filt & ~r_prev;
  assign w_fall = ~w_filt & r_prev;
  assign w_det  = BOTH_EDGES ? (w_rise | w_fall)
                             : ((w_rise & ~r_edge_sel) | (w_fall & r_edge_sel));
  assign w_clr  = (w_wr && (address == ADDR_EDGE_CAPTURE)) ? w_wdata : '0;

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_sel <= '0;
      r_irq_mask <= '0;
    end else if (w_wr) begin
      if (address == ADDR_EDGE_SEL) r_edge_sel <= w_wdata;
      if (address == ADDR_IRQ_MASK) r_irq_mask <= w_wdata;
    end
  end

  // Sticky edge capture; OR-ing det after the clear makes a new edge win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capture <= '0;
      r_prev    <= {WIDTH{IDLE_LEVEL}};
    end else begin
      r_capture <= (r_capture & ~w_clr) | w_det;
      r_prev    <= w_filt;
    end
  end

  // Level interrupt from any enabled pending capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_capture & r_irq_mask);
    end
  end

  // Read mux registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:         r_readdata <= 32'(w_filt);
        ADDR_EDGE_SEL:     r_readdata <= 32'(r_edge_sel);
        ADDR_IRQ_MASK:     r_readdata <= 32'(r_irq_mask);
        ADDR_EDGE_CAPTURE: r_readdata <= 32'(r_capture);
        default:           r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios_system_pio_edge_irq.sv
// Bench for nios_system_pio_edge_irq. Three instances share one bus:
//   dut0: WIDTH=4, no debounce, selectable edges, idle low
//   dut1: WIDTH=4, DEBOUNCE_CYCLES=8, selectable edges, idle low
//   dut2: WIDTH=4, no debounce, both edges, idle high
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_nios_system_pio_edge_irq;

  localparam int NDUT = 3;
  localparam int P_D  [NDUT] = '{0, 8, 0};
  localparam bit P_BE [NDUT] = '{1'b0, 1'b0, 1'b1};
  localparam bit P_IL [NDUT] = '{1'b0, 1'b0, 1'b1};

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [1:0]                 address = 2'd0;
  logic                       chipselect = 1'b0;
  logic                       write_n = 1'b1;
  logic [31:0]                writedata = 32'd0;
  logic [NDUT-1:0][3:0]       pins;
  logic [NDUT-1:0][31:0]      rd;
  logic [NDUT-1:0]            irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pin sample history, filtered value, registers.
  logic [3:0]  m_h    [NDUT][16];
  logic [3:0]  m_filt [NDUT];
  logic [3:0]  m_prev [NDUT];
  logic [3:0]  m_sel  [NDUT];
  logic [3:0]  m_mask [NDUT];
  logic [3:0]  m_cap  [NDUT];
  logic [31:0] m_rd   [NDUT];
  logic        m_irq  [NDUT];

  always #5 clk = ~clk;

  nios_system_pio_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .BOTH_EDGES(1'b0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(pins[0]), .readdata(rd[0]), .irq(irq_o[0]));

  nios_system_pio_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .BOTH_EDGES(1'b0), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(pins[1]), .readdata(rd[1]), .irq(irq_o[1]));

  nios_system_pio_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .BOTH_EDGES(1'b1), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(pins[2]), .readdata(rd[2]), .irq(irq_o[2]));

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int c = 0; c < NDUT; c++) begin
      for (int k = 0; k < 16; k++) m_h[c][k] = {4{P_IL[c]}};
      m_filt[c] = {4{P_IL[c]}};
      m_prev[c] = {4{P_IL[c]}};
      m_sel[c]  = 4'd0;
      m_mask[c] = 4'd0;
      m_cap[c]  = 4'd0;
      m_rd[c]   = 32'd0;
      m_irq[c]  = 1'b0;
    end
  endtask

  // One rising edge of behaviour. m_h[c][k] holds the pin value sampled
  // k+1 edges ago, so the synchronised value seen now is m_h[c][1]. A
  // filtered bit flips once the last D synchronised samples all disagree.
  task automatic model_step();
    logic       wr;
    logic       all_diff;
    logic [3:0] fc, rise, fall, det, clr, oc, om, os;
    wr = chipselect & ~write_n;
    for (int c = 0; c < NDUT; c++) begin
      oc   = m_cap[c];
      om   = m_mask[c];
      os   = m_sel[c];
      fc   = (P_D[c] == 0) ? m_h[c][1] : m_filt[c];
      rise = fc & ~m_prev[c];
      fall = ~fc & m_prev[c];
      det  = P_BE[c] ? (rise | fall) : ((rise & ~os) | (fall & os));
      case (address)
        2'd0:    m_rd[c] = {28'd0, fc};
        2'd1:    m_rd[c] = {28'd0, os};
        2'd2:    m_rd[c] = {28'd0, om};
        default: m_rd[c] = {28'd0, oc};
      endcase
      m_irq[c] = |(oc & om);
      clr = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
      m_cap[c] = (oc & ~clr) | det;
      if (wr && address == 2'd1) m_sel[c]  = writedata[3:0];
      if (wr && address == 2'd2) m_mask[c] = writedata[3:0];
      m_prev[c] = fc;
      if (P_D[c] > 0) begin
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= P_D[c]; k++) begin
            if (m_h[c][k][b] == m_filt[c][b]) all_diff = 1'b0;
          end
          if (all_diff) m_filt[c][b] = m_h[c][1][b];
        end
      end
      for (int k = 15; k > 0; k--) m_h[c][k] = m_h[c][k-1];
      m_h[c][0] = pins[c];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    address = a;
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pins[0] = 4'h0;
    pins[1] = 4'h0;
    pins[2] = 4'hF;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== 32'd0) begin
        n_fail++; $display("FAIL reset_rd dut%0d got=%h exp=%h", c, rd[c], 32'd0);
      end
      n_checks++;
      if (irq_o[c] !== 1'b0) begin
        n_fail++; $display("FAIL reset_irq dut%0d got=%b exp=0", c, irq_o[c]);
      end
    end
    reset_n = 1'b1;
    repeat (6) cycle();
    set_addr(2'd3);
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== 32'd0) begin
        n_fail++; $display("FAIL reset_no_capture dut%0d got=%h exp=%h", c, rd[c], 32'd0);
      end
    end
    set_addr(2'd0);
    n_checks++;
    if (rd[2] !== 32'hF) begin
      n_fail++; $display("FAIL reset_idle_high_data got=%h exp=%h", rd[2], 32'hF);
    end
  endtask

  task automatic test_capture_irq();
    pins[0] = 4'h1;
    repeat (4) cycle();
    set_addr(2'd3);
    n_checks++;
    if (rd[0] !== 32'h1) begin
      n_fail++; $display("FAIL capture_bit0 got=%h exp=%h", rd[0], 32'h1);
    end
    n_checks++;
    if (irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked got=%b exp=0", irq_o[0]);
    end
    bus_write(2'd2, 32'h1);
    n_checks++;
    if (irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_at_mask_edge got=%b exp=0", irq_o[0]);
    end
    cycle();
    n_checks++;
    if (irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL irq_after_mask got=%b exp=1", irq_o[0]);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL irq_at_clear_edge got=%b exp=1", irq_o[0]);
    end
    cycle();
    n_checks++;
    if (irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_after_clear got=%b exp=0", irq_o[0]);
    end
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (irq_o[c] !== m_irq[c]) begin
        n_fail++; $display("FAIL capture_irq_model dut%0d got=%b exp=%b", c, irq_o[c], m_irq[c]);
      end
    end
  endtask

  task automatic test_edge_sel();
    pins[0] = 4'h1;
    pins[1] = 4'h1;
    pins[2] = 4'h1;
    repeat (12) cycle();
    bus_write(2'd3, 32'hF);
    bus_write(2'd1, 32'h2);
    pins[0] = pins[0] | 4'h2;
    pins[2] = pins[2] | 4'h2;
    repeat (4) cycle();
    set_addr(2'd3);
    n_checks++;
    if (rd[0] !== 32'h0) begin
      n_fail++; $display("FAIL edge_sel_rise_ignored got=%h exp=%h", rd[0], 32'h0);
    end
    n_checks++;
    if (rd[2] !== 32'h2) begin
      n_fail++; $display("FAIL both_edges_rise got=%h exp=%h", rd[2], 32'h2);
    end
    pins[0] = pins[0] & ~4'h2;
    pins[2] = pins[2] & ~4'h2;
    repeat (4) cycle();
    set_addr(2'd3);
    n_checks++;
    if (rd[0] !== 32'h2) begin
      n_fail++; $display("FAIL edge_sel_fall got=%h exp=%h", rd[0], 32'h2);
    end
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== m_rd[c]) begin
        n_fail++; $display("FAIL edge_sel_model dut%0d got=%h exp=%h", c, rd[c], m_rd[c]);
      end
    end
  endtask

  task automatic test_debounce();
    int first_hit;
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    pins[1][2] = 1'b1;
    repeat (5) cycle();
    pins[1][2] = 1'b0;
    repeat (15) cycle();
    n_checks++;
    if (rd[1] !== 32'h1) begin
      n_fail++; $display("FAIL glitch_data got=%h exp=%h", rd[1], 32'h1);
    end
    set_addr(2'd3);
    n_checks++;
    if (rd[1] !== 32'h0) begin
      n_fail++; $display("FAIL glitch_capture got=%h exp=%h", rd[1], 32'h0);
    end
    address = 2'd0;
    cycle();
    pins[1][2] = 1'b1;
    first_hit = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (first_hit == 0 && rd[1][2] === 1'b1) first_hit = k;
    end
    // sync2 changes at edge 2, filt 8 edges later at 10, readdata at 11.
    n_checks++;
    if (first_hit != 11) begin
      n_fail++; $display("FAIL debounce_latency got=%0d exp=%0d", first_hit, 11);
    end
    pins[1][2] = 1'b0;
    repeat (14) cycle();
    set_addr(2'd3);
    n_checks++;
    if (rd[1] !== 32'h4) begin
      n_fail++; $display("FAIL debounce_capture got=%h exp=%h", rd[1], 32'h4);
    end
  endtask

  task automatic test_set_wins();
    bus_write(2'd3, 32'hF);
    pins[0][2] = 1'b1;
    cycle();
    cycle();
    bus_write(2'd3, 32'h4);
    set_addr(2'd3);
    n_checks++;
    if (rd[0] !== 32'h4) begin
      n_fail++; $display("FAIL set_wins_over_clear got=%h exp=%h", rd[0], 32'h4);
    end
    bus_write(2'd3, 32'h4);
    set_addr(2'd3);
    n_checks++;
    if (rd[0] !== 32'h0) begin
      n_fail++; $display("FAIL w1c_clear got=%h exp=%h", rd[0], 32'h0);
    end
  endtask

  task automatic test_write_ignore();
    bus_write(2'd0, 32'hFFFF_FFFF);
    set_addr(2'd0);
    n_checks++;
    if (rd[0] !== 32'h5) begin
      n_fail++; $display("FAIL data_write_ignored got=%h exp=%h", rd[0], 32'h5);
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    set_addr(2'd2);
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== 32'h0000_000F) begin
        n_fail++; $display("FAIL mask_readback dut%0d got=%h exp=%h", c, rd[c], 32'hF);
      end
    end
    bus_write(2'd1, 32'hFFFF_FFF0);
    set_addr(2'd1);
    n_checks++;
    if (rd[0] !== 32'h0) begin
      n_fail++; $display("FAIL sel_readback got=%h exp=%h", rd[0], 32'h0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NDUT; c++) begin
        if ($urandom_range(0, 5) == 0) pins[c] = pins[c] ^ (4'b0001 << $urandom_range(0, 3));
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      cycle();
      for (int c = 0; c < NDUT; c++) begin
        n_checks++;
        if (rd[c] !== m_rd[c]) begin
          n_fail++; $display("FAIL random_rd dut%0d cyc=%0d got=%h exp=%h", c, n, rd[c], m_rd[c]);
        end
        n_checks++;
        if (irq_o[c] !== m_irq[c]) begin
          n_fail++; $display("FAIL random_irq dut%0d cyc=%0d got=%b exp=%b", c, n, irq_o[c], m_irq[c]);
        end
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'hF);
    pins[0] = ~pins[0];
    pins[1] = ~pins[1];
    pins[2] = ~pins[2];
    repeat (4) cycle();
    address = 2'd3;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== 32'd0) begin
        n_fail++; $display("FAIL midreset_rd dut%0d got=%h exp=%h", c, rd[c], 32'd0);
      end
      n_checks++;
      if (irq_o[c] !== 1'b0) begin
        n_fail++; $display("FAIL midreset_irq dut%0d got=%b exp=0", c, irq_o[c]);
      end
    end
    @(negedge clk);
    pins[0] = 4'h0;
    pins[1] = 4'h0;
    pins[2] = 4'hF;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (14) cycle();
    set_addr(2'd3);
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== 32'd0) begin
        n_fail++; $display("FAIL postreset_capture dut%0d got=%h exp=%h", c, rd[c], 32'd0);
      end
    end
    set_addr(2'd2);
    for (int c = 0; c < NDUT; c++) begin
      n_checks++;
      if (rd[c] !== m_rd[c]) begin
        n_fail++; $display("FAIL postreset_mask dut%0d got=%h exp=%h", c, rd[c], m_rd[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_irq();
    test_edge_sel();
    test_debounce();
    test_set_wins();
    test_write_ignore();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
